// File: rtl/ram_bist_if.sv
// RAM-side bus of the BIST engine: write data, write enable, address, read data.
// Latency: none, plain wires; read data is combinational in address on the RAM side.
// Backpressure: none; the RAM accepts a write on every rising edge with mem_load=1.
//   master: the BIST engine (drives mem_in/mem_load/mem_address, samples mem_out)
//   slave : the RAM (samples write side, drives mem_out)
interface ram_bist_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] mem_in;
    logic                  mem_load;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_out;

    modport master (
        output mem_in,
        output mem_load,
        output mem_address,
        input  mem_out
    );

    modport slave (
        input  mem_in,
        input  mem_load,
        input  mem_address,
        output mem_out
    );
endinterface

// File: rtl/ram_bist.sv
// Memory BIST: fills every word with a 16-bit LFSR pattern, reads it all back and compares.
// Latency: 2*2^ADDR_WIDTH cycles from the edge sampling start to done.
// Backpressure: none; one word per cycle, start ignored while busy.
// Ports:
//   CLK, reset        clock, asynchronous active-high reset
//   start             begin a run (sampled in IDLE or DONE)
//   mem               RAM bus (master side of ram_bist_if)
//   busy, done        phase status (WRITE/READ, DONE)
//   pass              1 when done and no mismatches
//   err_count         saturating mismatch count
//   first_fail_addr   address of the first mismatching word, 0 if none
module ram_bist #(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    ram_bist_if.master            mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    // An all-zero seed would lock the LFSR at zero; the polynomial is 16-bit only.
    generate
        if (SEED == 16'h0000) begin : g_bad_seed
            $error("ram_bist: SEED must be nonzero");
        end
        if (DATA_WIDTH != 16) begin : g_bad_width
            $error("ram_bist: DATA_WIDTH must be 16");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [15:0]           ERR_MAX   = 16'hFFFF;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [15:0]           lfsr;
    logic                  fail_seen;

    logic [15:0]           lfsr_nxt;
    logic                  mismatch;
    logic                  at_last;

    // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1.
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    assign mismatch = (mem.mem_out != lfsr);
    // Phase end is the all-ones address so the compare never relies on wrap-around.
    assign at_last  = (addr == ADDR_LAST);

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            addr            <= '0;
            lfsr            <= SEED;
            err_count       <= '0;
            first_fail_addr <= '0;
            fail_seen       <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state           <= S_WRITE;
                        addr            <= '0;
                        lfsr            <= SEED;
                        err_count       <= '0;
                        first_fail_addr <= '0;
                        fail_seen       <= 1'b0;
                    end
                end

                S_WRITE: begin
                    if (at_last) begin
                        // Rewind the generator so the read phase regenerates the same stream.
                        state <= S_READ;
                        addr  <= '0;
                        lfsr  <= SEED;
                    end else begin
                        addr  <= addr + 1'b1;
                        lfsr  <= lfsr_nxt;
                    end
                end

                S_READ: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + 16'd1;
                        end
                        if (!fail_seen) begin
                            first_fail_addr <= addr;
                            fail_seen       <= 1'b1;
                        end
                    end
                    addr <= addr + 1'b1;
                    lfsr <= lfsr_nxt;
                    if (at_last) begin
                        state <= S_DONE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Gating with reset keeps a write from committing on the edge reset arrives,
    // independent of how quickly the state register clears.
    assign mem.mem_load    = (state == S_WRITE) && !reset;
    assign mem.mem_address = addr;
    assign mem.mem_in      = lfsr;

    assign busy = (state == S_WRITE) || (state == S_READ);
    assign done = (state == S_DONE);
    assign pass = done && (err_count == 16'd0);

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: RAM model with fault modes, write and result scoreboards.
module tb_ram_bist;

    localparam int          N    = 4096;
    localparam int          NS   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct packed {
        logic [11:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct packed {
        logic        p;
        logic [15:0] e;
        logic [11:0] f;
    } res_t;

    logic        CLK;
    logic        reset;
    logic        start;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [11:0] first_fail_addr;

    logic        start_s;
    logic        busy_s, done_s, pass_s;
    logic [15:0] err_s;
    logic [3:0]  ffa_s;

    int n_checks = 0;
    int n_err    = 0;
    int mode     = 0;   // 0 ideal, 1 bit3 stuck-at-0 at address 37, 2 load ignored
    logic        cap_en = 1'b0;
    int          n_cap  = 0;
    logic [15:0] cap [0:2];
    int          n_wr_s = 0;
    logic [19:0] wr_s [0:NS-1];

    wr_t  exp_wr_q  [$];
    res_t exp_res_q [$];

    logic [15:0] ram   [0:N-1];
    logic [15:0] ram_s [0:NS-1];
    logic [15:0] rd;

    ram_bist_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) mem_if ();
    ram_bist_if #(.ADDR_WIDTH(4),  .DATA_WIDTH(16)) mem_s_if ();

    ram_bist #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .SEED(SEED)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .start           (start),
        .mem             (mem_if),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr)
    );

    ram_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .SEED(SEED)) dut_s (
        .CLK             (CLK),
        .reset           (reset),
        .start           (start_s),
        .mem             (mem_s_if),
        .busy            (busy_s),
        .done            (done_s),
        .pass            (pass_s),
        .err_count       (err_s),
        .first_fail_addr (ffa_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // RAM models: synchronous write, combinational read.
    always @(posedge CLK) begin
        if (mem_if.mem_load) ram[mem_if.mem_address] <= mem_if.mem_in;
        if (mem_s_if.mem_load) ram_s[mem_s_if.mem_address] <= mem_s_if.mem_in;
    end

    always_comb begin
        rd = ram[mem_if.mem_address];
        if (mode == 1 && mem_if.mem_address == 12'd37) rd = rd & ~16'h0008;
        if (mode == 2) rd = 16'h0000;
    end
    assign mem_if.mem_out   = rd;
    assign mem_s_if.mem_out = ram_s[mem_s_if.mem_address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic push_writes();
        logic [15:0] v;
        v = SEED;
        for (int a = 0; a < N; a++) begin
            exp_wr_q.push_back('{a: a[11:0], d: v});
            v = lfsr_step(v);
        end
    endtask

    task automatic push_result(input logic p, input logic [15:0] e, input logic [11:0] f);
        exp_res_q.push_back('{p: p, e: e, f: f});
    endtask

    task automatic check_result(input string tag);
        res_t r;
        if (exp_res_q.size() == 0) begin
            chk({tag, "_res_q"}, 32'(exp_res_q.size()), 32'd1);
        end else begin
            r = exp_res_q.pop_front();
            chk({tag, "_pass"}, 32'(pass), 32'(r.p));
            chk({tag, "_err"},  32'(err_count), 32'(r.e));
            chk({tag, "_ffa"},  32'(first_fail_addr), 32'(r.f));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_load"}, 32'(mem_if.mem_load), 32'd0);
        chk({tag, "_addr"}, 32'(mem_if.mem_address), 32'd0);
        chk({tag, "_in"},   32'(mem_if.mem_in), 32'(SEED));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
        chk({tag, "_err"},  32'(err_count), 32'd0);
        chk({tag, "_ffa"},  32'(first_fail_addr), 32'd0);
    endtask

    // Pulse start for one cycle; returns #1 after the sampling edge E0.
    task automatic kick();
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done, bounded; also watch for busy/done overlap.
    task automatic wait_done(input string tag, output int edges);
        logic overlap;
        overlap = 1'b0;
        edges = 0;
        do begin
            @(posedge CLK);
            edges++;
            #1;
            if (busy && done) overlap = 1'b1;
        end while (!done && edges < 20000);
        chk({tag, "_busy_done"}, 32'(overlap), 32'd0);
        chk({tag, "_edges"}, 32'(edges), 32'(2 * N));
    endtask

    // Write scoreboard: every committed write must match the next expected word.
    always @(negedge CLK) begin
        if (!reset && mem_if.mem_load) begin
            if (exp_wr_q.size() == 0) begin
                chk("wr_q", 32'(exp_wr_q.size()), 32'd1);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("wr", {4'h0, mem_if.mem_address, mem_if.mem_in}, {4'h0, e.a, e.d});
                if (cap_en && n_cap < 3) begin
                    cap[n_cap] = mem_if.mem_in;
                    n_cap++;
                end
            end
        end
        if (!reset && mem_s_if.mem_load && n_wr_s < NS) begin
            wr_s[n_wr_s] = {mem_s_if.mem_address, mem_s_if.mem_in};
            n_wr_s++;
        end
    end

    initial begin
        int n;
        logic [15:0] v;
        logic [15:0] cap_exp [0:2];

        reset   = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge CLK);
        reset = 1'b0;

        // Ideal RAM.
        mode   = 0;
        cap_en = 1'b1;
        push_writes();
        push_result(1'b1, 16'd0, 12'd0);
        kick();
        wait_done("ideal", n);
        check_result("ideal");
        cap_en = 1'b0;
        cap_exp[0] = 16'hACE1;
        cap_exp[1] = 16'h59C3;
        cap_exp[2] = 16'hB387;
        for (int i = 0; i < 3; i++) chk($sformatf("first_wr%0d", i), 32'(cap[i]), 32'(cap_exp[i]));

        // Bit 3 stuck at 0 on address 37 (its pattern has bit 3 set).
        mode = 1;
        push_writes();
        push_result(1'b0, 16'd1, 12'd37);
        kick();
        wait_done("stuck", n);
        check_result("stuck");

        // RAM ignores writes: every word mismatches since the LFSR never hits 0.
        mode = 2;
        push_writes();
        push_result(1'b0, 16'd4096, 12'd0);
        kick();
        wait_done("noload", n);
        check_result("noload");

        // Reset in the middle of WRITE.
        mode = 0;
        push_writes();
        kick();
        repeat (99) @(posedge CLK);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(posedge CLK);
        #1;
        chk("midrst_hold_load", 32'(mem_if.mem_load), 32'd0);
        @(negedge CLK);
        reset = 1'b0;
        exp_wr_q.delete();
        @(posedge CLK);
        #1;
        chk("post_rst_load", 32'(mem_if.mem_load), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        push_writes();
        push_result(1'b1, 16'd0, 12'd0);
        kick();
        wait_done("rerun", n);
        check_result("rerun");

        // start held high: rerun immediately after one DONE cycle.
        push_writes();
        push_writes();
        push_result(1'b1, 16'd0, 12'd0);
        push_result(1'b1, 16'd0, 12'd0);
        @(negedge CLK);
        start = 1'b1;
        @(posedge CLK);
        #1;
        wait_done("held1", n);
        check_result("held1");
        @(posedge CLK);
        #1;
        chk("held_restart_done", 32'(done), 32'd0);
        chk("held_restart_busy", 32'(busy), 32'd1);
        wait_done("held2", n);
        start = 1'b0;
        check_result("held2");
        @(posedge CLK);
        #1;
        chk("done_hold", 32'(done), 32'd1);
        chk("done_hold_err", 32'(err_count), 32'd0);
        chk("wr_q_drained", 32'(exp_wr_q.size()), 32'd0);

        // Small configuration, ADDR_WIDTH = 4.
        @(negedge CLK);
        start_s = 1'b1;
        @(posedge CLK);
        #1;
        start_s = 1'b0;
        n = 0;
        do begin
            @(posedge CLK);
            n++;
            #1;
        end while (!done_s && n < 1000);
        chk("small_edges", 32'(n), 32'(2 * NS));
        chk("small_pass", 32'(pass_s), 32'd1);
        chk("small_err", 32'(err_s), 32'd0);
        chk("small_nwr", 32'(n_wr_s), 32'(NS));
        v = SEED;
        for (int k = 0; k < NS; k++) begin
            chk($sformatf("small_wr%0d", k), 32'(wr_s[k]), {12'h000, k[3:0], v});
            v = lfsr_step(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/ram_bist.md
# ram_bist

Synthesizable built-in self-test engine for the Hack data memory: the hardware initiator that drives a RAM4K-style port (`in`/`load`/`address`/`out`) from the other side. On `start` it fills every word with a 16-bit LFSR sequence, then reads every word back and compares it against the regenerated sequence. It reports pass/fail, an error count and the first failing address. It sits beside the RAM on the board-level wrapper and replaces the simulation-only write/read-back bench for on-hardware checks.

## Interface
Parameters:
- `ADDR_WIDTH`, default 12: address bits; depth = 2^ADDR_WIDTH words (4096).
- `DATA_WIDTH`, fixed 16: word width; the LFSR is defined for 16 bits only.
- `SEED`, default 16'hACE1: LFSR start value; must be nonzero (elaboration-time error if 0).

Ports:
- `CLK` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high; forces the reset state below.
- `start` in 1: begin a test; sampled only in IDLE or DONE.
- `mem_in` out 16: write data to RAM `in`.
- `mem_load` out 1: RAM write enable.
- `mem_address` out ADDR_WIDTH: RAM address.
- `mem_out` in 16: RAM read data; combinational in `mem_address`; writes commit on the rising `CLK` edge while `mem_load`=1.
- `busy` out 1: high in WRITE or READ.
- `done` out 1: high in DONE.
- `pass` out 1: valid when `done`=1; 1 iff `err_count`==0.
- `err_count` out 16: number of mismatching words; saturates at 16'hFFFF.
- `first_fail_addr` out ADDR_WIDTH: address of the first mismatch; 0 if none.

## Operation
- State machine: IDLE → WRITE → READ → DONE.
- IDLE: `start`=1 → WRITE. On entry: `addr`=0, `lfsr`=SEED, `err_count`=0, `first_fail_addr`=0, `fail_seen`=0.
- WRITE:
  - `mem_load`=1, `mem_address`=`addr`, `mem_in`=`lfsr`.
  - Each edge: `lfsr` advances and `addr` increments.
  - At `addr`=2^ADDR_WIDTH−1: → READ with `addr`=0 and `lfsr`=SEED.
- READ:
  - `mem_load`=0, `mem_address`=`addr`.
  - Each edge compares `mem_out` to `lfsr`. On mismatch: `err_count`+=1 (saturating). If `fail_seen`=0, then `first_fail_addr`=`addr` and `fail_seen`=1.
  - `lfsr` advances and `addr` increments.
  - At the last address: → DONE after that compare.
- DONE: outputs hold; `start`=1 → WRITE, with the same initialisation as IDLE.
- LFSR (Fibonacci, x^16+x^14+x^13+x^11+1): next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
  - Sequence from ACE1: ACE1, 59C3, B387, …
- `start` in WRITE or READ is ignored.
- `addr` is ADDR_WIDTH bits wide. The end of a phase is detected on the all-ones address, not on wrap-around.
- Outputs in IDLE: `mem_load`=0, `mem_address`=`addr`, `mem_in`=`lfsr`.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE
  - `mem_load`=0, `mem_address`=0, `mem_in`=SEED
  - `busy`=0, `done`=0, `pass`=0
  - `err_count`=0, `first_fail_addr`=0
- Reset asserted mid-WRITE: `mem_load` drops combinationally with reset, so no further write commits. Partial RAM contents are not cleaned up.
- Cycle numbering: edge E0 samples `start`=1.
  - Word k is written at edge E(k+1).
  - READ begins after edge E(N) (N = 2^ADDR_WIDTH); word k is compared at edge E(N+k+1).
  - DONE is entered after edge E(2N).
  - Default config: `done` rises after E8192; total runtime is 2N cycles.
- `busy` is high from after E0 through E(2N); `done` and `busy` are never high together.
- `pass`, `err_count` and `first_fail_addr` are stable whenever `done`=1.
- Restart from DONE: `done` falls after the edge that samples `start`.

## Test plan
- Ideal RAM4K model, `start` pulse for 1 cycle → address 0 written with 16'hACE1, 1 with 16'h59C3, 2 with 16'hB387. Then `done`=1 after exactly 8192 edges, with `pass`=1, `err_count`=0, `first_fail_addr`=0.
- RAM model with bit 3 stuck at 0 at address 12'd37 only → `pass`=0, `err_count`=1, `first_fail_addr`=37. The fault must corrupt that word's pattern: choose a seed, or inject the fault at an address whose pattern has bit 3 set.
- RAM model ignoring `load` (all reads return 0) → `err_count`=4096 and `first_fail_addr`=0. This holds because the LFSR is never 0, so every word mismatches.
- `reset` asserted at cycle 100 of WRITE → all outputs return to reset values that cycle; `mem_load`=0 thereafter. A new `start` then runs the full sequence and reports `pass`=1.
- `start` held high throughout a run → no restart until DONE, then immediate rerun. `done` is high for 1 cycle between runs; the second run gives an identical result.
- `ADDR_WIDTH`=4 → `done` after 32 edges; 16 words written with the ACE1 sequence; `pass`=1.
